// File: rtl/am29xx_pkg.sv
// -----------------------------------------------------------------------------
// am29xx_pkg
//   Definitions shared by the am2925 wait/ready controller and its counter:
//   - state_e     : controller state encoding (2 bits)
//   - wait_lookup : maps a 2-bit device-region select to its wait-state count
//   - default wait-state counts and widths used by the top-level parameters
// -----------------------------------------------------------------------------
package am29xx_pkg;

  // Controller states. The encoding is fixed so that the state can be
  // observed on a logic analyser and read without a decode table.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RDY  = 2'd3
  } state_e;

  // Default region timing and widths.
  localparam int WAIT0_DEF = 0;
  localparam int WAIT1_DEF = 3;
  localparam int WAIT2_DEF = 5;
  localparam int WAIT3_DEF = 15;
  localparam int CW_DEF    = 4;
  localparam int TMO_DEF   = 31;

  // Region select -> wait-state count. The table values are passed in so
  // that each instance can carry its own timing; the caller truncates the
  // result to its counter width.
  function automatic int wait_lookup(input logic [1:0] sel,
                                     input int w0, input int w1,
                                     input int w2, input int w3);
    int n;
    unique case (sel)
      2'd0:    n = w0;
      2'd1:    n = w1;
      2'd2:    n = w2;
      default: n = w3;
    endcase
    return n;
  endfunction

endpackage : am29xx_pkg

// File: rtl/am2925_wait_cnt.sv
// -----------------------------------------------------------------------------
// am2925_wait_cnt
//   Loadable W-bit down-counter with zero and one detection. Used both for
//   the wait-state count and for the optional waitack_ timeout.
//   Priority on a rising edge: rst_i > clr_i > load_i > dec_i.
//   Decrementing stops at zero (it never wraps).
//
// Ports
//   clk_i      in   clock
//   rst_i      in   synchronous active-high reset (count -> 0)
//   clr_i      in   synchronous clear (count -> 0)
//   load_i     in   load load_val_i
//   load_val_i in   W  value to load
//   dec_i      in   decrement by one
//   cnt_o      out  W  current count
//   zero_o     out  count == 0
//   one_o      out  count == 1
// -----------------------------------------------------------------------------
module am2925_wait_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o,
  output logic         one_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample their inputs from the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == W'(1));

endmodule : am2925_wait_cnt

// File: rtl/am2925_wait_ctrl.sv
// -----------------------------------------------------------------------------
// am2925_wait_ctrl
//   Slow-device side of the am2925 wait/ready handshake. On an accepted
//   access request it looks up the wait-state count of the selected region,
//   asks the am2925 to stretch its cycle (waitreq_), waits for the
//   acknowledge (waitack_), counts the wait states and then gives a single
//   one-clock ready_ pulse so the clock generator resumes.
//
//   Optional feature (macro AM2925_WAIT_CTRL_TIMEOUT_EN): if waitack_ has not
//   been seen after TMO clocks in REQ, the request is abandoned, the sticky
//   tmo flag is set and the am2925 is released through the normal ready_
//   pulse. Without the macro REQ waits indefinitely and tmo is tied 0.
//
// Parameters
//   WAIT0..WAIT3  wait states per region (0 = no wait requested)
//   CW            counter width; every WAITn must fit in CW bits
//   TMO           timeout limit in clocks (timeout feature only)
//
// Ports
//   clkin     in   clock, all state changes on the rising edge
//   reset     in   synchronous active-high reset
//   req_      in   access request, active low, level
//   sel       in   2  region select, sampled when the request is accepted
//   waitack_  in   wait acknowledge from the am2925, active low
//   waitreq_  out  wait request to the am2925, active low
//   ready_    out  one-clock ready pulse to the am2925, active low
//   busy      out  high while the controller is not IDLE
//   wcnt      out  CW remaining wait count (diagnostic)
//   tmo       out  sticky timeout flag (0 when the feature is not built)
// -----------------------------------------------------------------------------
module am2925_wait_ctrl
  import am29xx_pkg::*;
#(
  parameter int WAIT0 = WAIT0_DEF,
  parameter int WAIT1 = WAIT1_DEF,
  parameter int WAIT2 = WAIT2_DEF,
  parameter int WAIT3 = WAIT3_DEF,
  parameter int CW    = CW_DEF,
  parameter int TMO   = TMO_DEF
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic          req_,
  input  logic [1:0]    sel,
  input  logic          waitack_,
  output logic          waitreq_,
  output logic          ready_,
  output logic          busy,
  output logic [CW-1:0] wcnt,
  output logic          tmo
);

  // Elaboration-time sanity checks on the configuration.
  localparam int CNT_MAX = (2 ** CW) - 1;

  if ((WAIT0 > CNT_MAX) || (WAIT1 > CNT_MAX) ||
      (WAIT2 > CNT_MAX) || (WAIT3 > CNT_MAX)) begin : g_bad_wait
    $error("am2925_wait_ctrl: a WAITn value does not fit in CW bits");
  end

  if (TMO < 1) begin : g_bad_tmo
    $error("am2925_wait_ctrl: TMO must be at least 1");
  end

  state_e        state_q;
  state_e        state_d;
  logic          armed_q;
  logic          armed_d;

  logic [CW-1:0] n_sel;       // wait states of the currently selected region
  logic          wc_load;
  logic          wc_dec;
  logic          wc_clr;
  logic          wc_zero;
  logic          wc_one;
  logic          to_expired;  // timeout reached while in REQ

  assign n_sel = CW'(wait_lookup(sel, WAIT0, WAIT1, WAIT2, WAIT3));

  // ---------------------------------------------------------------------------
  // Wait-state counter
  // ---------------------------------------------------------------------------
  am2925_wait_cnt #(
    .W (CW)
  ) u_wait_cnt (
    .clk_i      (clkin),
    .rst_i      (reset),
    .clr_i      (wc_clr),
    .load_i     (wc_load),
    .load_val_i (n_sel),
    .dec_i      (wc_dec),
    .cnt_o      (wcnt),
    .zero_o     (wc_zero),
    .one_o      (wc_one)
  );

  // ---------------------------------------------------------------------------
  // Optional waitack_ timeout
  // ---------------------------------------------------------------------------
`ifdef AM2925_WAIT_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);

  logic [TW-1:0] to_cnt_unused;
  logic          to_zero;
  logic          to_one;
  logic          to_clr;
  logic          tmo_q;
  logic          tmo_set;

  // Loaded with TMO on the edge that enters REQ and decremented on every
  // edge spent in REQ, so it reaches one on the TMO-th clock in REQ. The
  // zero term only guards against a counter that was never loaded.
  am2925_wait_cnt #(
    .W (TW)
  ) u_tmo_cnt (
    .clk_i      (clkin),
    .rst_i      (reset),
    .clr_i      (to_clr),
    .load_i     (wc_load),
    .load_val_i (TW'(TMO)),
    .dec_i      (state_q == REQ),
    .cnt_o      (to_cnt_unused),
    .zero_o     (to_zero),
    .one_o      (to_one)
  );

  assign to_expired = to_one | to_zero;
  assign to_clr     = (state_q == REQ) && (state_d != REQ);
  // An acknowledge on the expiry edge wins over the timeout.
  assign tmo_set    = (state_q == REQ) && waitack_ && to_expired;

  always_ff @(posedge clkin) begin
    if (reset) begin
      tmo_q <= 1'b0;
    end else if (tmo_set) begin
      tmo_q <= 1'b1;
    end
  end

  assign tmo = tmo_q;
`else
  assign to_expired = 1'b0;
  assign tmo        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    wc_load = 1'b0;
    wc_dec  = 1'b0;
    wc_clr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // armed prevents a req_ held low across a finished transaction from
        // starting another one; req_ must be seen high in IDLE first.
        if (req_) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          if (n_sel != '0) begin
            wc_load = 1'b1;
            state_d = REQ;
          end
        end
      end

      REQ: begin
        if (!waitack_) begin
          state_d = WAIT;
        end else if (to_expired) begin
          state_d = RDY;
        end
      end

      WAIT: begin
        // Zero is unreachable in normal operation; treating it like one
        // keeps a corrupted count from hanging the am2925.
        if (wc_one || wc_zero) begin
          state_d = RDY;
        end else begin
          wc_dec = 1'b1;
        end
      end

      RDY: begin
        state_d = IDLE;
        wc_clr  = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  // Outputs are decoded from the registered state only, so waitreq_ and
  // ready_ are glitch-free and can never be low together.
  assign waitreq_ = (state_q != REQ);
  assign ready_   = (state_q != RDY);
  assign busy     = (state_q != IDLE);

endmodule : am2925_wait_ctrl

// File: tb/tb_am2925_wait_ctrl.sv
// -----------------------------------------------------------------------------
// tb_am2925_wait_ctrl
//   Directed testbench for am2925_wait_ctrl with default parameters
//   (WAIT0=0, WAIT1=3, WAIT2=5, WAIT3=15, CW=4, TMO=31). A table of
//   per-clock vectors covers reset, zero-wait regions and two complete
//   transactions; hand-written sequences cover long acknowledge delays,
//   re-arming, reset in the middle of a transaction and, when built with
//   AM2925_WAIT_CTRL_TIMEOUT_EN, the timeout abort.
// -----------------------------------------------------------------------------
module tb_am2925_wait_ctrl;

  logic       clkin = 1'b0;
  logic       reset;
  logic       req_;
  logic [1:0] sel;
  logic       waitack_;
  logic       waitreq_;
  logic       ready_;
  logic       busy;
  logic [3:0] wcnt;
  logic       tmo;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clkin = ~clkin;

  am2925_wait_ctrl dut (
    .clkin    (clkin),
    .reset    (reset),
    .req_     (req_),
    .sel      (sel),
    .waitack_ (waitack_),
    .waitreq_ (waitreq_),
    .ready_   (ready_),
    .busy     (busy),
    .wcnt     (wcnt),
    .tmo      (tmo)
  );

  typedef struct {
    logic       rst;
    logic       req_n;
    logic [1:0] sel;
    logic       ack_n;
    logic       e_wreq_n;
    logic       e_rdy_n;
    logic       e_busy;
    logic [3:0] e_wcnt;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic wr, input logic rd,
                         input logic bz, input logic [3:0] wc,
                         input logic tm);
    check({tag, " waitreq_"}, 32'(waitreq_), 32'(wr));
    check({tag, " ready_"},   32'(ready_),   32'(rd));
    check({tag, " busy"},     32'(busy),     32'(bz));
    check({tag, " wcnt"},     32'(wcnt),     32'(wc));
    check({tag, " tmo"},      32'(tmo),      32'(tm));
  endtask

  task automatic add(input logic rst, input logic rq, input logic [1:0] s,
                     input logic ak, input logic wr, input logic rd,
                     input logic bz, input logic [3:0] wc);
    vq.push_back('{rst, rq, s, ak, wr, rd, bz, wc});
  endtask

  int pulses;
  int lat;
  bit found;

  initial begin
    reset    = 1'b1;
    req_     = 1'b1;
    sel      = 2'd0;
    waitack_ = 1'b1;

    //   rst req sel ack | wreq rdy busy wcnt
    add(1, 1, 0, 1,   1, 1, 0, 0);           // reset
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 1, 1, 1, 0, 0);           // region 0: no handshake
    add(0, 1, 0, 1,   1, 1, 0, 0);           // re-arm
    add(0, 0, 1, 1,   0, 1, 1, 3);           // edge 0: accept region 1
    add(0, 0, 2, 0,   1, 1, 1, 3);           // edge 1: ack, sel change ignored
    add(0, 0, 2, 1,   1, 1, 1, 2);
    add(0, 0, 2, 1,   1, 1, 1, 1);
    add(0, 0, 2, 1,   1, 0, 1, 1);           // edge 4: ready_ pulse
    add(0, 1, 0, 1,   1, 1, 0, 0);           // edge 5: IDLE
    add(0, 1, 0, 1,   1, 1, 0, 0);           // re-arm in IDLE
    add(0, 0, 2, 0,   0, 1, 1, 5);           // accept region 2, ack early
    add(0, 0, 3, 0,   1, 1, 1, 5);           // WAIT, later sel ignored
    add(0, 0, 3, 0,   1, 1, 1, 4);
    add(0, 0, 3, 0,   1, 1, 1, 3);
    add(0, 0, 3, 0,   1, 1, 1, 2);
    add(0, 0, 3, 0,   1, 1, 1, 1);
    add(0, 0, 3, 0,   1, 0, 1, 1);           // ready_ pulse
    add(0, 0, 3, 0,   1, 1, 0, 0);           // IDLE, req_ still low
    add(0, 0, 3, 0,   1, 1, 0, 0);           // no retrigger

    foreach (vq[i]) begin
      reset    = vq[i].rst;
      req_     = vq[i].req_n;
      sel      = vq[i].sel;
      waitack_ = vq[i].ack_n;
      tick();
      chk_out($sformatf("vec%0d", i), vq[i].e_wreq_n, vq[i].e_rdy_n,
              vq[i].e_busy, vq[i].e_wcnt, 1'b0);
    end

    // Region 3 with the acknowledge held off for four extra clocks.
    req_ = 1'b1; waitack_ = 1'b1;
    tick();
    req_ = 1'b0; sel = 2'd3;
    tick();
    chk_out("A accept", 1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
    sel = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_out($sformatf("A req%0d", k), 1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
    end
    waitack_ = 1'b0;
    tick();
    chk_out("A ack", 1'b1, 1'b1, 1'b1, 4'd15, 1'b0);
    waitack_ = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k < 15) begin
        check($sformatf("A wait%0d wcnt", k), 32'(wcnt), 32'(15 - k));
        check($sformatf("A wait%0d ready_", k), 32'(ready_), 32'd1);
      end else begin
        chk_out("A ready", 1'b1, 1'b0, 1'b1, 4'd1, 1'b0);
      end
    end
    tick();
    chk_out("A idle", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

    // req_ still held low: no second transaction.
    pulses = 0;
    repeat (20) begin
      tick();
      if (!ready_ || busy) pulses++;
    end
    check("B held-low activity", 32'(pulses), 32'd0);

    // One clock of req_ high re-arms; next request runs.
    req_ = 1'b1;
    tick();
    req_ = 1'b0; sel = 2'd1; waitack_ = 1'b0;
    found = 1'b0; lat = -1; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!ready_) begin
        pulses++;
        if (!found) begin
          found = 1'b1;
          lat = i;
        end
      end
    end
    check("B rearm ready_ edge", 32'(lat), 32'd4);
    check("B rearm pulse count", 32'(pulses), 32'd1);
    check("B rearm busy after", 32'(busy), 32'd0);

    // Reset in WAIT with wcnt=2.
    req_ = 1'b1;
    tick();
    req_ = 1'b0; sel = 2'd1; waitack_ = 1'b0;
    tick();
    tick();
    tick();
    chk_out("C pre-reset", 1'b1, 1'b1, 1'b1, 4'd2, 1'b0);
    reset = 1'b1;
    tick();
    chk_out("C reset", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    reset = 1'b0; req_ = 1'b1;
    pulses = 0;
    repeat (8) begin
      tick();
      if (!ready_ || busy) pulses++;
    end
    check("C no pulse after reset", 32'(pulses), 32'd0);

    // Reset wins over an acceptable request on the same edge.
    req_ = 1'b0; sel = 2'd2; waitack_ = 1'b1; reset = 1'b1;
    tick();
    chk_out("C reset wins", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    reset = 1'b0;
    tick();
    chk_out("C accept after reset", 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
    reset = 1'b1; req_ = 1'b1;
    tick();
    reset = 1'b0;

`ifdef AM2925_WAIT_CTRL_TIMEOUT_EN
    // waitack_ stuck high: abort after 31 clocks in REQ.
    tick();
    req_ = 1'b0; sel = 2'd1; waitack_ = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("D req%0d waitreq_", k), 32'(waitreq_), 32'd0);
      check($sformatf("D req%0d tmo", k), 32'(tmo), 32'd0);
    end
    tick();
    chk_out("D abort", 1'b1, 1'b0, 1'b1, 4'd3, 1'b1);
    tick();
    chk_out("D idle", 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    req_ = 1'b1;
    repeat (3) tick();
    check("D tmo sticky", 32'(tmo), 32'd1);
    reset = 1'b1;
    tick();
    check("D tmo reset", 32'(tmo), 32'd0);
    reset = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_am2925_wait_ctrl
